lct_l1a_latency_meter: RTL and testbench
========================================

Name: lct_l1a_latency_meter

Overview:
Measures the actual PLCT-to-L1A latency in bx so the LCT delay-line settings (DELAY, XL1ADLY, OPT_COP, L1FD) can be calibrated from hardware instead of computed by hand. The delay chain pushes LCTs forward to meet the L1A. This block runs the same relationship the other way: it starts on PLCT, stops on L1A, and accumulates statistics over a fixed number of samples. It sits beside the LCT delay chain on the same CLK domain. Its results are read by the slow-control register file.

Parameters:
CNT_W, 8, latency counter width; the maximum measurable latency is 2^CNT_W-1 bx.
NSAMP_LOG2, 4, log2 of the number of samples per run (default 16).

Ports:
CLK  in  1  system bx clock
RST  in  1  synchronous, active-high reset
START  in  1  single-cycle pulse; clears statistics and begins a run
PLCT  in  1  pretrigger LCT, one-cycle pulse
L1A  in  1  level-1 accept, one-cycle pulse
BUSY  out  1  a run is in progress
DONE  out  1  level; the run completed with 2^NSAMP_LOG2 samples
LAST_LAT  out  CNT_W  latency of the most recent sample
MIN_LAT  out  CNT_W  minimum latency in the run
MAX_LAT  out  CNT_W  maximum latency in the run
AVG_LAT  out  CNT_W  floor(sum / 2^NSAMP_LOG2); valid when DONE=1
NSAMP  out  NSAMP_LOG2+1  number of samples recorded in the run
TIMEOUTS  out  8  count of PLCTs with no L1A inside the window; saturates at 255

Behaviour:
- Reset (RST=1 at a CLK edge):
  - state=IDLE.
  - BUSY=0, DONE=0.
  - LAST_LAT=0, MAX_LAT=0, MIN_LAT=all ones, AVG_LAT=0, NSAMP=0, TIMEOUTS=0.
  - Internal counter and sum are cleared.
  - RST mid-run aborts the run with no partial results kept.
- All outputs are registered.
- States: IDLE, WAIT_LCT, COUNT, DONE.
- IDLE / DONE:
  - START=1 clears all statistics to their reset values except state.
  - Next cycle: WAIT_LCT, BUSY=1, DONE=0.
  - PLCT and L1A are ignored.
- START in WAIT_LCT or COUNT restarts the run: statistics are cleared, the counter is discarded, next state is WAIT_LCT.
- WAIT_LCT:
  - PLCT=1: counter<=1, next state COUNT.
  - L1A without PLCT is ignored.
  - PLCT and L1A in the same cycle: treated as PLCT only. Latency 0 is not measurable.
- COUNT: the counter equals the number of cycles elapsed since the PLCT cycle.
  - PLCT during COUNT is ignored; there is no retrigger.
  - L1A=1 records sample=counter. If PLCT is at cycle t and L1A at cycle t+k, the sample is k.
  - On a recorded sample, one cycle after L1A:
    - LAST_LAT=k, MIN_LAT=min(MIN_LAT,k), MAX_LAT=max(MAX_LAT,k).
    - sum+=k; the sum is CNT_W+NSAMP_LOG2 bits and never overflows.
    - NSAMP+=1.
  - If NSAMP reaches 2^NSAMP_LOG2 on that update:
    - AVG_LAT=sum>>NSAMP_LOG2.
    - State DONE: DONE=1, BUSY=0, all in the same cycle as the final statistics.
  - Otherwise the next state is WAIT_LCT.
  - If the counter equals 2^CNT_W-1 and L1A=0: TIMEOUTS+=1 (saturating at 255), no sample is recorded, next state WAIT_LCT.
  - L1A coinciding with the terminal count is a valid sample with k=2^CNT_W-1, not a timeout.
- DONE holds all results until the next START or RST.

Decomposition:
- Shared package lct_meas_pkg:
  - the state encoding (IDLE=0, WAIT_LCT=1, COUNT=2, DONE=3);
  - CNT_W and NSAMP_LOG2 defaults;
  - the TIMEOUTS width constant.
- One sub-module, lat_stats_acc, owns the statistics datapath:
  - inputs: clear, sample valid, sample value;
  - holds LAST/MIN/MAX/sum/NSAMP and the average computation.
- The FSM and counter stay in the top module.

Test Plan:
- RST, START, then 16 runs of PLCT with L1A 100 cycles later -> NSAMP=16, LAST/MIN/MAX/AVG=100, DONE=1, BUSY=0, TIMEOUTS=0.
- Latencies alternating 98/102 over 16 samples -> MIN=98, MAX=102, AVG=100. Latencies 1..16 -> AVG=8 (136>>4).
- PLCT with no L1A for 300 cycles -> TIMEOUTS=1 at cycle 255, state WAIT_LCT, NSAMP unchanged. L1A exactly at k=255 -> sample 255, TIMEOUTS unchanged.
- PLCT and L1A in the same cycle in WAIT_LCT, then L1A 50 cycles later -> sample 50. A second PLCT at +20 is ignored.
- After 8 samples assert RST -> all outputs at reset values, MIN_LAT=8'hFF. START after 8 samples -> NSAMP=0, BUSY=1, run restarts.
- TIMEOUTS saturation: 300 timed-out PLCTs -> TIMEOUTS=255.

Source files
------------

// File: rtl/lct_meas_pkg.sv
// Shared definitions for the PLCT-to-L1A latency meter: FSM state encoding,
// default widths and the width of the timeout counter.
package lct_meas_pkg;

  // Default latency counter width; the longest measurable latency is 2^CNT_W-1 bx.
  localparam int CNT_W_DEF      = 8;
  // Default log2 of the number of samples collected per run.
  localparam int NSAMP_LOG2_DEF = 4;
  // Width of the saturating timeout counter.
  localparam int TO_W           = 8;

  // Run-control FSM states.
  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_LCT = 2'd1;
  localparam logic [1:0] ST_COUNT    = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

endpackage

// File: rtl/lat_stats_acc.sv
// Statistics datapath for the latency meter: keeps the last, minimum and
// maximum sample, the running sum and the sample count, and produces the
// floored average once the run fills.
module lat_stats_acc
  import lct_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NSAMP_LOG2 = NSAMP_LOG2_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  smp_vld_p0,
  input  logic [CNT_W-1:0]      smp_p0,
  output logic [CNT_W-1:0]      last_lat,
  output logic [CNT_W-1:0]      min_lat,
  output logic [CNT_W-1:0]      max_lat,
  output logic [CNT_W-1:0]      avg_lat,
  output logic [NSAMP_LOG2:0]   nsamp,
  output logic                  fill
);

  // The sum holds 2^NSAMP_LOG2 samples of at most 2^CNT_W-1, so it cannot wrap.
  localparam int SUM_W = CNT_W + NSAMP_LOG2;
  localparam int NS_W  = NSAMP_LOG2 + 1;
  // Count value just before the run is full.
  localparam logic [NSAMP_LOG2:0] NS_LAST = {1'b0, {NSAMP_LOG2{1'b1}}};

  logic [SUM_W-1:0] sum_p1;
  logic [SUM_W-1:0] sum_nxt;

  // Floor of sum / 2^NSAMP_LOG2 is simply the upper CNT_W bits of the sum.
  function automatic logic [CNT_W-1:0] avg_floor(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:NSAMP_LOG2];
  endfunction

  assign sum_nxt = sum_p1 + SUM_W'(smp_p0);
  // This sample completes the run; the FSM uses it to enter DONE on the same edge.
  assign fill    = smp_vld_p0 && (nsamp == NS_LAST);

  // Stage p0 -> p1: fold the accepted sample into the running statistics.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      last_lat <= '0;
      min_lat  <= '1;
      max_lat  <= '0;
      avg_lat  <= '0;
      nsamp    <= '0;
      sum_p1   <= '0;
    end else if (smp_vld_p0) begin
      last_lat <= smp_p0;
      if (smp_p0 < min_lat) min_lat <= smp_p0;
      if (smp_p0 > max_lat) max_lat <= smp_p0;
      sum_p1   <= sum_nxt;
      nsamp    <= nsamp + NS_W'(1);
      if (fill) avg_lat <= avg_floor(sum_nxt);
    end
  end

endmodule

// File: rtl/lct_l1a_latency_meter.sv
// PLCT-to-L1A latency meter. A run starts on START, times each PLCT until
// the following L1A, and accumulates 2^NSAMP_LOG2 samples; PLCTs that see no
// L1A before the counter reaches its terminal count are tallied as timeouts.
module lct_l1a_latency_meter
  import lct_meas_pkg::*;
#(
  parameter int CNT_W      = CNT_W_DEF,
  parameter int NSAMP_LOG2 = NSAMP_LOG2_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  START,
  input  logic                  PLCT,
  input  logic                  L1A,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_W-1:0]      LAST_LAT,
  output logic [CNT_W-1:0]      MIN_LAT,
  output logic [CNT_W-1:0]      MAX_LAT,
  output logic [CNT_W-1:0]      AVG_LAT,
  output logic [NSAMP_LOG2:0]   NSAMP,
  output logic [TO_W-1:0]       TIMEOUTS
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt_p0;
  logic             in_count;
  logic             smp_vld_p0;
  logic             tmo;
  logic             fill;

  // Saturating increment for the timeout tally.
  function automatic logic [TO_W-1:0] sat_inc(input logic [TO_W-1:0] v);
    return (v == {TO_W{1'b1}}) ? v : v + TO_W'(1);
  endfunction

  // A START on this edge overrides any sample or timeout in flight.
  assign in_count   = (state == ST_COUNT) && !START;
  // L1A at the terminal count is still a valid sample, so it wins over timeout.
  assign smp_vld_p0 = in_count && L1A;
  assign tmo        = in_count && !L1A && (cnt_p0 == CNT_MAX);

  // Run-control FSM, latency counter and timeout tally.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      cnt_p0   <= '0;
      TIMEOUTS <= '0;
    end else if (START) begin
      state    <= ST_WAIT_LCT;
      BUSY     <= 1'b1;
      DONE     <= 1'b0;
      cnt_p0   <= '0;
      TIMEOUTS <= '0;
    end else begin
      case (state)
        ST_WAIT_LCT: begin
          // A coincident L1A is ignored: zero latency is not measurable.
          if (PLCT) begin
            cnt_p0 <= CNT_W'(1);
            state  <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (smp_vld_p0) begin
            if (fill) begin
              state <= ST_DONE;
              BUSY  <= 1'b0;
              DONE  <= 1'b1;
            end else begin
              state <= ST_WAIT_LCT;
            end
          end else if (tmo) begin
            TIMEOUTS <= sat_inc(TIMEOUTS);
            state    <= ST_WAIT_LCT;
          end else begin
            cnt_p0 <= cnt_p0 + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  lat_stats_acc #(
    .CNT_W      (CNT_W),
    .NSAMP_LOG2 (NSAMP_LOG2)
  ) u_stats (
    .clk        (CLK),
    .rst        (RST),
    .clr        (START),
    .smp_vld_p0 (smp_vld_p0),
    .smp_p0     (cnt_p0),
    .last_lat   (LAST_LAT),
    .min_lat    (MIN_LAT),
    .max_lat    (MAX_LAT),
    .avg_lat    (AVG_LAT),
    .nsamp      (NSAMP),
    .fill       (fill)
  );

endmodule

// File: tb/tb_lct_l1a_latency_meter.sv
// Scoreboard bench for lct_l1a_latency_meter. The driver keeps a behavioural
// model (list of recorded latencies, timeout tally, run flags) and pushes the
// expected output snapshot for a given cycle; the monitor pops and compares.
module tb_lct_l1a_latency_meter;

  localparam int NS = 16;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       PLCT = 1'b0;
  logic       L1A = 1'b0;
  logic       BUSY, DONE;
  logic [7:0] LAST_LAT, MIN_LAT, MAX_LAT, AVG_LAT, TIMEOUTS;
  logic [4:0] NSAMP;

  lct_l1a_latency_meter #(.CNT_W(8), .NSAMP_LOG2(4)) dut (
    .CLK(CLK), .RST(RST), .START(START), .PLCT(PLCT), .L1A(L1A),
    .BUSY(BUSY), .DONE(DONE), .LAST_LAT(LAST_LAT), .MIN_LAT(MIN_LAT),
    .MAX_LAT(MAX_LAT), .AVG_LAT(AVG_LAT), .NSAMP(NSAMP), .TIMEOUTS(TIMEOUTS)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int due; int id; bit busy; bit done;
    int last; int mn; int mx; int avg; int ns; int to;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  // Reference model state
  int m_s[$];
  int m_to = 0;
  int m_last = 0;
  bit m_busy = 0;
  bit m_done = 0;
  int m_id = 0;

  task automatic expect_at(input int due);
    exp_t e;
    int mn, mx, sum;
    mn = 255; mx = 0; sum = 0;
    foreach (m_s[i]) begin
      if (m_s[i] < mn) mn = m_s[i];
      if (m_s[i] > mx) mx = m_s[i];
      sum += m_s[i];
    end
    e.due = due; e.id = m_id; e.busy = m_busy; e.done = m_done;
    e.last = m_last; e.mn = mn; e.mx = mx;
    e.avg = m_done ? sum / NS : 0;
    e.ns = m_s.size(); e.to = m_to;
    m_id++;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1; step(); RST = 1'b0;
    m_s.delete(); m_to = 0; m_last = 0; m_busy = 0; m_done = 0;
    expect_at(cyc);
  endtask

  task automatic do_start();
    START = 1'b1; step(); START = 1'b0;
    m_s.delete(); m_to = 0; m_last = 0; m_busy = 1; m_done = 0;
    expect_at(cyc);
  endtask

  // One PLCT followed by L1A k cycles later; optional coincident L1A on the
  // PLCT cycle and an extra PLCT at offset extra_at (0 = none), both ignored.
  task automatic measure(input int k, input bit same, input int extra_at);
    PLCT = 1'b1; L1A = same; step(); PLCT = 1'b0; L1A = 1'b0;
    for (int j = 1; j < k; j++) begin
      PLCT = (j == extra_at);
      step();
      PLCT = 1'b0;
    end
    L1A = 1'b1; step(); L1A = 1'b0;
    m_s.push_back(k); m_last = k;
    if (m_s.size() == NS) begin m_done = 1; m_busy = 0; end
    expect_at(cyc);
  endtask

  // PLCT with no L1A: the timeout is registered 255 cycles later.
  task automatic timeout();
    PLCT = 1'b1; step(); PLCT = 1'b0;
    repeat (255) step();
    if (m_to < 255) m_to++;
    expect_at(cyc);
  endtask

  // Random L1A pulses while waiting for a PLCT; nothing may change.
  task automatic wait_noise(input int n);
    for (int j = 0; j < n; j++) begin
      L1A = 1'($urandom_range(0, 1)); step(); L1A = 1'b0;
    end
    expect_at(cyc);
  endtask

  // Random PLCT/L1A after the run completed; results must hold.
  task automatic done_noise(input int n);
    for (int j = 0; j < n; j++) begin
      PLCT = 1'($urandom_range(0, 1)); L1A = 1'($urandom_range(0, 1));
      step();
      PLCT = 1'b0; L1A = 1'b0;
    end
    expect_at(cyc);
  endtask

  // Monitor: compare each expected snapshot on the falling edge of its cycle.
  exp_t me;
  always @(negedge CLK) begin
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      me = sb.pop_front();
      total++;
      if (me.due != cyc || BUSY !== me.busy || DONE !== me.done ||
          LAST_LAT !== 8'(me.last) || MIN_LAT !== 8'(me.mn) ||
          MAX_LAT !== 8'(me.mx) || AVG_LAT !== 8'(me.avg) ||
          NSAMP !== 5'(me.ns) || TIMEOUTS !== 8'(me.to)) begin
        bad++;
        $display("FAIL chk%0d cyc=%0d due=%0d got busy=%0d done=%0d last=%0d min=%0d max=%0d avg=%0d ns=%0d to=%0d want busy=%0d done=%0d last=%0d min=%0d max=%0d avg=%0d ns=%0d to=%0d",
                 me.id, cyc, me.due, BUSY, DONE, LAST_LAT, MIN_LAT, MAX_LAT,
                 AVG_LAT, NSAMP, TIMEOUTS, me.busy, me.done, me.last, me.mn,
                 me.mx, me.avg, me.ns, me.to);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog cyc=%0d pending=%0d", cyc, sb.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    step();
    do_reset();

    // Constant latency 100
    do_start();
    repeat (NS) measure(100, 1'b0, 0);
    done_noise(20);

    // Alternating 98/102
    do_start();
    for (int i = 0; i < NS; i++) measure((i % 2 == 0) ? 98 : 102, 1'b0, 0);

    // Latencies 1..16 -> average 8
    do_start();
    for (int i = 1; i <= NS; i++) measure(i, 1'b0, 0);

    // Timeout, then a sample exactly at the terminal count
    do_start();
    timeout();
    wait_noise(10);
    measure(255, 1'b0, 0);
    wait_noise(10);

    // Coincident PLCT+L1A, second PLCT at +20 ignored, L1A at +50
    measure(50, 1'b1, 20);
    for (int i = 0; i < 6; i++) measure(10 + i, 1'b0, 0);

    // Reset after 8 samples
    do_reset();
    wait_noise(5);
    do_start();

    // Restart after 8 samples, and restart during COUNT
    for (int i = 0; i < 8; i++) measure(20 + 3 * i, 1'b0, 0);
    do_start();
    measure(7, 1'b0, 0);
    PLCT = 1'b1; step(); PLCT = 1'b0;
    repeat (10) step();
    do_start();

    // Randomised runs
    for (int r = 0; r < 2; r++) begin
      if (r > 0) do_start();
      while (m_s.size() < NS) begin
        wait_noise($urandom_range(0, 4));
        k = $urandom_range(1, 255);
        measure(k, 1'($urandom_range(0, 1)),
                (k > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, k - 1) : 0);
      end
      done_noise(8);
    end

    // Timeout saturation
    do_start();
    repeat (260) timeout();
    measure(33, 1'b0, 0);

    repeat (3) step();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL pending_expectations got=%0d want=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
